// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI register-file target and the PWM block that consumes its registers.
// Holds the FSM encoding, frame geometry, rw-bit values and register index map.
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_COMMIT,
    ST_ERR
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int REG_OUT_LO     = 0;
  localparam int REG_OUT_HI     = 1;
  localparam int REG_OE         = 2;
  localparam int REG_PWM_PERIOD = 3;
  localparam int REG_PWM_DUTY   = 4;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus rise/fall detection against a history flop.
// Edge pulses appear SYNC_STAGES+1 clk after the pin changes; no backpressure.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_hist <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target owning NUM_REGS x DATA_W registers; write frames commit one clk after the
// synchronised CS rise (SYNC_STAGES+2 clk after the pin), read frames return data in the same frame.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_spi_sclk,
  input  logic                       i_spi_copi,
  input  logic                       i_spi_cs,
  output logic                       o_spi_cipo,
  output logic                       o_spi_cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] o_regs_flat,
  output logic                       o_wr_strobe,
  output logic [ADDR_W-1:0]          o_wr_addr,
  output logic                       o_frame_err,
  output logic                       o_addr_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CMD_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int ARM_W   = $clog2(SYNC_STAGES + 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_copi, w_copi_rise, w_copi_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_spi_sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_spi_copi),
    .o_level(w_copi), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_spi_cs),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  assign w_unused = &{1'b0, w_sclk_lvl, w_copi_rise, w_copi_fall};

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [CMD_W-1:0]           r_cmd;
  logic [DATA_W-1:0]          r_data;
  logic [DATA_W-1:0]          r_rd_shift;
  logic                       r_cipo;
  logic [NUM_REGS*DATA_W-1:0] r_regs;
  logic [ADDR_W-1:0]          r_wr_addr;
  logic                       r_wr_strobe;
  logic                       r_frame_err;
  logic                       r_addr_err;
  logic                       r_fall_pend;
  logic [ARM_W-1:0]           r_arm_cnt;
  logic                       r_armed;

  logic [CMD_W-1:0]  w_cmd_next;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic              w_addr_ok;
  logic [DATA_W-1:0] w_rd_val;

  assign w_cmd_next = {r_cmd[CMD_W-2:0], w_copi};
  assign w_cmd_addr = w_cmd_next[ADDR_W-1:0];
  assign w_addr_ok  = int'(r_cmd[ADDR_W-1:0]) < NUM_REGS;

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(w_cmd_addr) == i) w_rd_val = r_regs[i*DATA_W +: DATA_W];
    end
  end

  // The CS synchroniser resets high, so a pin already low at reset release shows up as a
  // spurious fall; frames are only accepted once a genuine CS-high level has been seen.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_data      <= '0;
      r_rd_shift  <= '0;
      r_cipo      <= 1'b0;
      r_regs      <= '0;
      r_wr_addr   <= '0;
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      r_addr_err  <= 1'b0;
      r_fall_pend <= 1'b0;
      r_arm_cnt   <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      r_addr_err  <= 1'b0;
      if (r_arm_cnt != ARM_W'(SYNC_STAGES)) r_arm_cnt <= r_arm_cnt + 1'b1;
      else if (w_cs_lvl)                    r_armed   <= 1'b1;
      if (w_cs_lvl) r_cipo <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_cipo <= 1'b0;
          if (r_armed && (w_cs_fall || r_fall_pend)) begin
            r_state     <= ST_CMD;
            r_cnt       <= '0;
            r_fall_pend <= 1'b0;
          end
        end
        ST_CMD: begin
          if (w_cs_rise) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (w_sclk_rise) begin
            r_cmd <= w_cmd_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(CMD_W - 1)) begin
              r_state    <= ST_DATA;
              r_rd_shift <= (w_cmd_next[CMD_W-1] == RW_READ) ? w_rd_val : '0;
            end
          end
        end
        ST_DATA: begin
          if (w_cs_rise) begin
            if (r_cnt == CNT_W'(FRAME_W)) begin
              r_state <= ST_COMMIT;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end else if (w_sclk_rise) begin
            if (r_cnt == CNT_W'(FRAME_W)) begin
              r_state <= ST_ERR;
            end else begin
              r_data <= {r_data[DATA_W-2:0], w_copi};
              r_cnt  <= r_cnt + 1'b1;
            end
          end
          if (w_sclk_fall && r_cmd[CMD_W-1] == RW_READ && !w_cs_lvl) begin
            r_cipo     <= r_rd_shift[DATA_W-1];
            r_rd_shift <= {r_rd_shift[DATA_W-2:0], 1'b0};
          end
        end
        ST_COMMIT: begin
          if (!w_addr_ok) begin
            r_addr_err <= 1'b1;
          end else if (r_cmd[CMD_W-1] == RW_WRITE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (int'(r_cmd[ADDR_W-1:0]) == i) r_regs[i*DATA_W +: DATA_W] <= r_data;
            end
            r_wr_strobe <= 1'b1;
            r_wr_addr   <= r_cmd[ADDR_W-1:0];
          end
          if (w_cs_fall) r_fall_pend <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          if (w_cs_rise) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_spi_cipo    = r_cipo & ~w_cs_lvl;
  assign o_spi_cipo_oe = ~w_cs_lvl;
  assign o_regs_flat   = r_regs;
  assign o_wr_strobe   = r_wr_strobe;
  assign o_wr_addr     = r_wr_addr;
  assign o_frame_err   = r_frame_err;
  assign o_addr_err    = r_addr_err;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: bit-banged SPI frames with hand-computed expectations.
module tb_spi_regfile_peripheral;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        copi = 1'b0;
  logic        cs = 1'b1;
  logic        cipo;
  logic        cipo_oe;
  logic [39:0] regs_flat;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic        frame_err;
  logic        addr_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr = 0, n_ferr = 0, n_aerr = 0;
  int s_wr, s_ferr, s_aerr;
  logic [7:0] rx;

  spi_regfile_peripheral dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_spi_sclk   (sclk),
    .i_spi_copi   (copi),
    .i_spi_cs     (cs),
    .o_spi_cipo   (cipo),
    .o_spi_cipo_oe(cipo_oe),
    .o_regs_flat  (regs_flat),
    .o_wr_strobe  (wr_strobe),
    .o_wr_addr    (wr_addr),
    .o_frame_err  (frame_err),
    .o_addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) n_wr++;
    if (frame_err) n_ferr++;
    if (addr_err)  n_aerr++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_wr   = n_wr;
    s_ferr = n_ferr;
    s_aerr = n_aerr;
  endtask

  // Bits go out MSB first; CIPO is sampled just before each data-phase rising edge.
  task automatic spi_bits(input logic [16:0] bits, input int nbits, output logic [7:0] rxo);
    rxo = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      copi = bits[nbits-1-i];
      wait_clk(HALF);
      if (i >= 8 && i < 16) rxo = {rxo[6:0], cipo};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [16:0] bits, input int nbits, output logic [7:0] rxo);
    cs = 1'b0;
    wait_clk(HALF);
    spi_bits(bits, nbits, rxo);
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(1);
    chk("rst_regs", regs_flat, 40'h0);
    chk("rst_wr_addr", wr_addr, 7'h0);
    chk("rst_cipo", cipo, 1'b0);
    chk("rst_oe", cipo_oe, 1'b0);
    chk("rst_pulses", n_wr + n_ferr + n_aerr, 0);
    wait_clk(8);

    // Write 0xA5 to reg 0
    snap();
    cs = 1'b0;
    wait_clk(HALF);
    chk("t1_oe_low_cs", cipo_oe, 1'b1);
    spi_bits(17'h080A5, 16, rx);
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(10);
    chk("t1_oe_high_cs", cipo_oe, 1'b0);
    chk("t1_cipo_write", rx, 8'h00);
    chk("t1_regs", regs_flat, 40'h00_00_00_00_A5);
    chk("t1_wr_cnt", n_wr - s_wr, 1);
    chk("t1_wr_addr", wr_addr, 7'd0);
    chk("t1_ferr", n_ferr - s_ferr, 0);
    chk("t1_aerr", n_aerr - s_aerr, 0);

    // Write 0x37 to reg 4, then read it back
    snap();
    frame(17'h08437, 16, rx);
    chk("t2_regs", regs_flat, 40'h37_00_00_00_A5);
    chk("t2_wr_addr", wr_addr, 7'd4);
    chk("t2_wr_cnt", n_wr - s_wr, 1);
    snap();
    frame(17'h00400, 16, rx);
    chk("t2_read_cipo", rx, 8'h37);
    chk("t2_read_regs", regs_flat, 40'h37_00_00_00_A5);
    chk("t2_read_wr", n_wr - s_wr, 0);
    chk("t2_read_errs", (n_ferr - s_ferr) + (n_aerr - s_aerr), 0);

    // Out-of-range write
    snap();
    frame(17'h085FF, 16, rx);
    chk("t3_regs", regs_flat, 40'h37_00_00_00_A5);
    chk("t3_aerr", n_aerr - s_aerr, 1);
    chk("t3_wr", n_wr - s_wr, 0);
    chk("t3_wr_addr_held", wr_addr, 7'd4);

    // Short frame, then a good frame to reg 1
    snap();
    frame(17'h00204, 10, rx);
    chk("t4_ferr", n_ferr - s_ferr, 1);
    chk("t4_regs", regs_flat, 40'h37_00_00_00_A5);
    snap();
    frame(17'h0813C, 16, rx);
    chk("t4_regs_after", regs_flat, 40'h37_00_00_3C_A5);
    chk("t4_ferr_after", n_ferr - s_ferr, 0);
    chk("t4_wr_after", n_wr - s_wr, 1);

    // 17 edges
    snap();
    frame(17'h10533, 17, rx);
    chk("t5_ferr", n_ferr - s_ferr, 1);
    chk("t5_regs", regs_flat, 40'h37_00_00_3C_A5);
    chk("t5_wr", n_wr - s_wr, 0);

    // Reset in the middle of a frame
    snap();
    cs = 1'b0;
    wait_clk(HALF);
    spi_bits(17'h00083, 8, rx);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    spi_bits(17'h00011, 8, rx);
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(10);
    chk("t6_regs", regs_flat, 40'h0);
    chk("t6_wr_addr", wr_addr, 7'd0);
    chk("t6_wr", n_wr - s_wr, 0);
    chk("t6_ferr", n_ferr - s_ferr, 0);
    chk("t6_aerr", n_aerr - s_aerr, 0);
    snap();
    frame(17'h08255, 16, rx);
    chk("t6_next_regs", regs_flat, 40'h00_00_55_00_00);
    chk("t6_next_wr_addr", wr_addr, 7'd2);
    chk("t6_next_wr", n_wr - s_wr, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_regfile_peripheral.md
Name: spi_regfile_peripheral

Overview:
- Parametrised SPI mode-0 target that owns a register file of NUM_REGS registers, each DATA_W bits wide.
- Supports write frames and read-back frames. Read data is driven on CIPO during the data phase of the same frame.
- Sits between the off-chip SPI pins and the PWM/output-enable logic, which consumes the flattened register bus and the per-write strobe.
- Also reports framing and address errors for debug counters.

Parameters:
- NUM_REGS, 5, number of implemented registers (addresses 0..NUM_REGS-1).
- DATA_W, 8, register and data-phase width in bits.
- ADDR_W, 7, address field width in bits; FRAME_W = 1 + ADDR_W + DATA_W.
- SYNC_STAGES, 2, synchroniser flops per SPI input (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- spi_sclk  input  1  SPI clock, asynchronous to clk.
- spi_copi  input  1  controller-out data, asynchronous.
- spi_cs  input  1  active-low chip select, asynchronous.
- spi_cipo  output  1  target-out data.
- spi_cipo_oe  output  1  CIPO output enable; high only while CS is low.
- regs_flat  output  NUM_REGS*DATA_W  register contents; register i occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  output  1  one-cycle pulse when a write commits.
- wr_addr  output  ADDR_W  address of the last committed write; valid with wr_strobe, held afterwards.
- frame_err  output  1  one-cycle pulse when a frame is aborted because of a bad bit count.
- addr_err  output  1  one-cycle pulse when a frame targets address >= NUM_REGS.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is synchronous and active-low; all state is reset on a clk edge while rst_n = 0.
- Reset values:
  - regs_flat = 0, wr_addr = 0.
  - spi_cipo = 0, spi_cipo_oe = 0, all pulses = 0.
  - Synchroniser flops for spi_sclk and spi_copi reset to 0; for spi_cs they reset to 1 (idle).
  - State machine resets to IDLE.
- Synchronisation: each input passes through SYNC_STAGES flops. Edges are detected between the last stage and one extra history flop. All logic uses only the synchronised signals.
- Frame format: MSB first. Bit 0 is rw (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits. COPI is sampled on synchronised SCLK rising edges while CS is low.
- State machine:
  - IDLE -> CMD on CS falling edge; bit counter cleared.
  - CMD: shift 1+ADDR_W bits. After the last address bit -> DATA.
    - For a read, the read value is latched at this point (register value, or 0 if the address is out of range).
  - DATA: shift DATA_W bits.
    - Read: on each synchronised SCLK falling edge, drive the next bit onto spi_cipo, MSB first. The first bit is driven on the falling edge that follows the last address bit.
    - Additional rising edges beyond FRAME_W -> ERR.
  - DATA, on CS rising edge with exactly FRAME_W bits -> COMMIT.
  - COMMIT (one cycle), then IDLE.
    - Write, address in range: the register updates and wr_strobe pulses in this cycle; wr_addr is updated.
    - Write, address out of range: no register change; addr_err pulses.
    - Read, address out of range: addr_err pulses.
    - Read frames never modify registers.
  - CS rising in CMD or DATA with fewer than FRAME_W bits: frame discarded, frame_err pulses, -> IDLE.
  - ERR: discard the frame; frame_err pulses once on the CS rising edge, then -> IDLE.
- Latency: register update occurs 1 clk after the synchronised CS rising edge is detected, i.e. SYNC_STAGES+2 clk after the pin rises.
- Simultaneous events:
  - An SCLK rising edge detected in the same clk as a CS rising edge is ignored.
  - A CS falling edge while in COMMIT is honoured on the next cycle: IDLE is entered, then CMD. This requires at least 2 clk of CS-high time.
- Output enable: spi_cipo_oe = ~cs_sync. spi_cipo = 0 whenever CS is high or during a write frame.
- Reset mid-frame: the partial frame is lost and registers clear. Because the CS synchroniser resets high, the block waits in IDLE for a fresh CS falling edge.
- Timing constraint: SCLK high and low times must each be at least SYNC_STAGES+2 clk periods.

Decomposition:
- Shared package spi_regfile_pkg holds:
  - state encoding (IDLE, CMD, DATA, COMMIT, ERR);
  - the FRAME_W computation;
  - the RW_WRITE/RW_READ constants.
  The PWM block imports the register index constants from the same package (REG_OUT_LO=0 … REG_PWM_DUTY=4).
- Sub-module spi_sync_edge (parameter SYNC_STAGES, RESET_VAL): synchroniser plus rise/fall detector, instantiated once each for spi_sclk, spi_copi and spi_cs.

Test Plan:
- Write 0x80_A5 (write, addr 0, data 0xA5): regs_flat[7:0] = 0xA5, wr_strobe high 1 clk, wr_addr = 0, no errors.
- Write 0x84_37 then read frame 0x04_00: reg 4 = 0x37; during the read, CIPO emits 0,0,1,1,0,1,1,1; regs unchanged; no wr_strobe.
- Write 0x85_FF (addr 5 >= NUM_REGS): all registers unchanged, addr_err pulses once, wr_strobe stays 0.
- CS raised after 10 bits of 0x81_xx: frame_err pulses, reg 1 unchanged. Next frame 0x81_3C writes 0x3C correctly.
- 17 SCLK edges in one frame: frame_err pulses, no register change.
- rst_n low for 1 clk after 8 bits of a frame, then CS stays low for 8 more edges and rises: all regs 0, no strobe, no errors. The next complete frame commits normally.
